// File: rtl/mem_responder_if.sv
// Memory-side bus bundle: initiator port, host port, and responder status.
// master = initiator/host driver, slave = mem_responder.
interface mem_responder_if #(
  parameter int MEM_AW = 16,
  parameter int MEM_DW = 32,
  parameter int CNT_W  = 32
);
  logic              mem_req;
  logic              mem_write;
  logic [MEM_AW-1:0] mem_addr;
  logic [MEM_DW-1:0] mem_wdata;
  logic              mem_rdata_vld;
  logic [MEM_DW-1:0] mem_rdata;
  logic              host_req;
  logic              host_we;
  logic [MEM_AW-1:0] host_addr;
  logic [MEM_DW-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rdata_vld;
  logic [MEM_DW-1:0] host_rdata;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  wr_cnt;
  logic              addr_err;

  modport master (
    output mem_req, mem_write, mem_addr, mem_wdata,
    output host_req, host_we, host_addr, host_wdata,
    input  mem_rdata_vld, mem_rdata, host_gnt, host_rdata_vld, host_rdata,
    input  rd_cnt, wr_cnt, addr_err
  );

  modport slave (
    input  mem_req, mem_write, mem_addr, mem_wdata,
    input  host_req, host_we, host_addr, host_wdata,
    output mem_rdata_vld, mem_rdata, host_gnt, host_rdata_vld, host_rdata,
    output rd_cnt, wr_cnt, addr_err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-array memory responder: initiator has priority over the host port,
// reads return in order after RD_LAT cycles, writes commit at acceptance.
module mem_responder #(
  parameter int MEM_AW   = 16,
  parameter int MEM_DW   = 32,
  parameter int DEPTH_AW = 10,
  parameter int RD_LAT   = 2,
  parameter int CNT_W    = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_responder_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_AW;

  logic [MEM_DW-1:0]   mem_q  [DEPTH];
  logic                vld_q  [RD_LAT];
  logic                tag_q  [RD_LAT];
  logic [MEM_DW-1:0]   data_q [RD_LAT];
  logic [MEM_DW-1:0]   mem_rdata_q, host_rdata_q;
  logic [CNT_W-1:0]    rd_cnt_q, wr_cnt_q;
  logic                addr_err_q;

  logic                acc_d, acc_host_d, acc_we_d, acc_in_rng_d;
  logic [MEM_AW-1:0]   acc_addr_d;
  logic [MEM_DW-1:0]   acc_wdata_d;
  logic [DEPTH_AW-1:0] acc_idx_d;
  logic                mem_dlv, host_dlv;

  // One access per cycle; the host only gets the slot the initiator leaves idle.
  always_comb begin
    acc_d        = bus.mem_req | bus.host_req;
    acc_host_d   = ~bus.mem_req;
    acc_we_d     = bus.mem_req ? bus.mem_write : bus.host_we;
    acc_addr_d   = bus.mem_req ? bus.mem_addr  : bus.host_addr;
    acc_wdata_d  = bus.mem_req ? bus.mem_wdata : bus.host_wdata;
    acc_in_rng_d = (acc_addr_d >> DEPTH_AW) == '0;
    acc_idx_d    = DEPTH_AW'(acc_addr_d);
  end

  assign bus.host_gnt = bus.host_req & ~bus.mem_req;

  // Array and read-data pipeline carry no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (acc_d && acc_we_d && acc_in_rng_d) mem_q[acc_idx_d] <= acc_wdata_d;
    data_q[0] <= acc_in_rng_d ? mem_q[acc_idx_d] : '0;
    for (int i = 1; i < RD_LAT; i++) data_q[i] <= data_q[i-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        vld_q[i] <= 1'b0;
        tag_q[i] <= 1'b0;
      end
      mem_rdata_q  <= '0;
      host_rdata_q <= '0;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      vld_q[0] <= acc_d & ~acc_we_d;
      tag_q[0] <= acc_host_d;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
      if (mem_dlv)  mem_rdata_q  <= data_q[RD_LAT-1];
      if (host_dlv) host_rdata_q <= data_q[RD_LAT-1];
      if (bus.mem_req && bus.mem_write)  wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      if (bus.mem_req && !bus.mem_write) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      if (acc_d && !acc_in_rng_d) addr_err_q <= 1'b1;
    end
  end

  // Outputs show the pipeline head while valid and otherwise hold the last delivery.
  assign mem_dlv            = vld_q[RD_LAT-1] & ~tag_q[RD_LAT-1];
  assign host_dlv           = vld_q[RD_LAT-1] &  tag_q[RD_LAT-1];
  assign bus.mem_rdata_vld  = mem_dlv;
  assign bus.mem_rdata      = mem_dlv ? data_q[RD_LAT-1] : mem_rdata_q;
  assign bus.host_rdata_vld = host_dlv;
  assign bus.host_rdata     = host_dlv ? data_q[RD_LAT-1] : host_rdata_q;
  assign bus.rd_cnt         = rd_cnt_q;
  assign bus.wr_cnt         = wr_cnt_q;
  assign bus.addr_err       = addr_err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Drives five responders (RD_LAT 1,2,3,4,8) with identical traffic and checks
// each against a queue-based model of the memory and its response timing.
module tb_mem_responder;
  localparam int N = 5;

  function automatic int lat_of(input int g);
    case (g)
      0: return 1;
      1: return 2;
      2: return 3;
      3: return 4;
      default: return 8;
    endcase
  endfunction

  logic        clk = 1'b0, rst = 1'b1;
  logic        req = 1'b0, mwe = 1'b0, hreq = 1'b0, hwe = 1'b0;
  logic [15:0] maddr = '0, haddr = '0;
  logic [31:0] mwd = '0, hwd = '0;

  logic [N-1:0] o_mv, o_hv, o_gnt, o_err;
  logic [31:0]  o_md [N];
  logic [31:0]  o_hd [N];
  logic [31:0]  o_rd [N];
  logic [31:0]  o_wr [N];

  for (genvar g = 0; g < N; g++) begin : gd
    mem_responder_if #(.MEM_AW(16), .MEM_DW(32), .CNT_W(32)) bus ();
    assign bus.mem_req    = req;
    assign bus.mem_write  = mwe;
    assign bus.mem_addr   = maddr;
    assign bus.mem_wdata  = mwd;
    assign bus.host_req   = hreq;
    assign bus.host_we    = hwe;
    assign bus.host_addr  = haddr;
    assign bus.host_wdata = hwd;
    assign o_mv[g]  = bus.mem_rdata_vld;
    assign o_md[g]  = bus.mem_rdata;
    assign o_hv[g]  = bus.host_rdata_vld;
    assign o_hd[g]  = bus.host_rdata;
    assign o_gnt[g] = bus.host_gnt;
    assign o_rd[g]  = bus.rd_cnt;
    assign o_wr[g]  = bus.wr_cnt;
    assign o_err[g] = bus.addr_err;
    mem_responder #(.MEM_AW(16), .MEM_DW(32), .DEPTH_AW(10), .RD_LAT(lat_of(g)), .CNT_W(32))
      dut (.clk(clk), .rst(rst), .bus(bus));
  end

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst) assert (!$isunknown(req) && !$isunknown(hreq)) else $error("X on request line");

  // Reference model: word array, per-DUT queue of responses with due cycle.
  typedef struct packed { logic [31:0] due; logic host; logic [31:0] data; } rsp_t;
  logic [31:0]  mdl [1024];
  rsp_t         q [N][$];
  logic [N-1:0] e_mv, e_hv;
  logic [31:0]  e_md [N];
  logic [31:0]  e_hd [N];
  logic [31:0]  e_rd, e_wr;
  logic         e_err;
  logic [31:0]  got [N][$];
  int           cyc = 0;
  int           total = 0, bad = 0;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      e_md[i] = '0;
      e_hd[i] = '0;
    end
    e_mv = '0; e_hv = '0; e_rd = '0; e_wr = '0; e_err = 1'b0;
  endtask

  // Advance one clock, updating the model with whatever was presented before the edge.
  task automatic tick();
    logic acc, host, we, inr;
    logic [15:0] a;
    logic [31:0] d;
    rsp_t r;
    acc  = !rst && (req || hreq);
    host = !req;
    we   = req ? mwe : hwe;
    a    = req ? maddr : haddr;
    d    = req ? mwd : hwd;
    inr  = (a >> 10) == 0;
    if (acc && !we)
      for (int i = 0; i < N; i++) begin
        r.due = 32'(cyc + lat_of(i)); r.host = host; r.data = inr ? mdl[a[9:0]] : 32'h0;
        q[i].push_back(r);
      end
    if (acc && we && inr) mdl[a[9:0]] = d;
    if (acc && req) begin
      if (we) e_wr = e_wr + 1; else e_rd = e_rd + 1;
    end
    if (acc && !inr) e_err = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    e_mv = '0; e_hv = '0;
    for (int i = 0; i < N; i++)
      if (q[i].size() > 0 && q[i][0].due == 32'(cyc)) begin
        r = q[i].pop_front();
        if (r.host) begin e_hv[i] = 1'b1; e_hd[i] = r.data; end
        else begin e_mv[i] = 1'b1; e_md[i] = r.data; end
      end
  endtask

  task automatic host_op(input logic we, input logic [15:0] a, input logic [31:0] d);
    hreq = 1'b1; hwe = we; haddr = a; hwd = d;
    tick();
    hreq = 1'b0; hwe = 1'b0;
  endtask

  task automatic mem_op(input logic we, input logic [15:0] a, input logic [31:0] d);
    req = 1'b1; mwe = we; maddr = a; mwd = d;
    tick();
    req = 1'b0; mwe = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      total++;
      if ({o_mv[i], o_hv[i], o_md[i], o_hd[i], o_rd[i], o_wr[i], o_err[i]} !== '0) begin
        bad++;
        $display("FAIL reset dut%0d vld=%b/%b rdata=%h/%h cnt=%0d/%0d err=%b want all 0",
                 i, o_mv[i], o_hv[i], o_md[i], o_hd[i], o_rd[i], o_wr[i], o_err[i]);
      end
    end
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_preload();
    for (int a = 0; a < 64; a++) host_op(1'b1, 16'(a), $urandom);
  endtask

  task automatic test_host_then_read();
    host_op(1'b1, 16'd5, 32'h11);
    host_op(1'b1, 16'd6, 32'h22);
    req = 1'b1; mwe = 1'b0; maddr = 16'd5;
    tick();
    total++;
    if (o_mv[1] !== 1'b0) begin bad++; $display("FAIL early_vld got=%b want=0", o_mv[1]); end
    maddr = 16'd6;
    tick();
    req = 1'b0;
    total++;
    if ({o_mv[1], o_md[1]} !== {1'b1, 32'h11}) begin
      bad++; $display("FAIL first_rsp got vld=%b data=%h want 1/00000011", o_mv[1], o_md[1]);
    end
    tick();
    total++;
    if ({o_mv[1], o_md[1]} !== {1'b1, 32'h22}) begin
      bad++; $display("FAIL second_rsp got vld=%b data=%h want 1/00000022", o_mv[1], o_md[1]);
    end
    total++;
    if (o_rd[1] !== 32'd2) begin bad++; $display("FAIL rd_cnt got=%0d want=2", o_rd[1]); end
    repeat (8) tick();
  endtask

  task automatic test_raw();
    mem_op(1'b1, 16'd3, 32'hDEADBEEF);
    mem_op(1'b0, 16'd3, 32'h0);
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < N; i++)
        if (lat_of(i) - 1 == j) begin
          total++;
          if ({o_mv[i], o_md[i]} !== {1'b1, 32'hDEADBEEF}) begin
            bad++; $display("FAIL raw dut%0d got vld=%b data=%h want 1/deadbeef", i, o_mv[i], o_md[i]);
          end
        end
      tick();
    end
    for (int i = 0; i < N; i++) begin
      total++;
      if (o_wr[i] !== 32'd1) begin bad++; $display("FAIL wr_cnt dut%0d got=%0d want=1", i, o_wr[i]); end
    end
  endtask

  task automatic test_arbitration();
    int hcnt [N];
    for (int i = 0; i < N; i++) hcnt[i] = 0;
    hreq = 1'b1; hwe = 1'b0; haddr = 16'd6;
    req = 1'b1; mwe = 1'b0; maddr = 16'd5;
    for (int k = 0; k < 14; k++) begin
      if (k == 4) req = 1'b0;
      #1;
      if (k <= 4) begin
        total++;
        if (o_gnt !== (k == 4 ? {N{1'b1}} : {N{1'b0}})) begin
          bad++; $display("FAIL host_gnt cyc%0d got=%b want=%0d", k, o_gnt, k == 4);
        end
      end
      tick();
      if (k == 4) hreq = 1'b0;
      total++;
      if ({o_mv, o_hv} !== {e_mv, e_hv}) begin
        bad++; $display("FAIL arb_tags cyc%0d got mv=%b hv=%b want mv=%b hv=%b", k, o_mv, o_hv, e_mv, e_hv);
      end
      for (int i = 0; i < N; i++) hcnt[i] += int'(o_hv[i]);
    end
    for (int i = 0; i < N; i++) begin
      total++;
      if (hcnt[i] != 1 || o_hd[i] !== 32'h22) begin
        bad++; $display("FAIL host_rsp dut%0d got n=%0d data=%h want 1/00000022", i, hcnt[i], o_hd[i]);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] old0;
    old0 = mdl[0];
    total++;
    if (o_err !== '0) begin bad++; $display("FAIL err_pre got=%b want=0", o_err); end
    for (int i = 0; i < N; i++) got[i].delete();
    req = 1'b1; mwe = 1'b1; maddr = 16'h0400; mwd = 32'h55;
    tick();
    mwe = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k == 1) maddr = 16'h0000;
      if (k == 2) req = 1'b0;
      tick();
      for (int i = 0; i < N; i++) if (o_mv[i]) got[i].push_back(o_md[i]);
    end
    for (int i = 0; i < N; i++) begin
      total++;
      if (got[i].size() != 2 || got[i][0] !== 32'h0 || got[i][1] !== old0 || o_err[i] !== 1'b1) begin
        bad++;
        $display("FAIL oor dut%0d got n=%0d d0=%h d1=%h err=%b want 2/0/%h/1", i, got[i].size(),
                 got[i].size() > 0 ? got[i][0] : 32'hx, got[i].size() > 1 ? got[i][1] : 32'hx, o_err[i], old0);
      end
    end
    repeat (5) tick();
    total++;
    if (o_err !== {N{1'b1}}) begin bad++; $display("FAIL err_sticky got=%b want=11111", o_err); end
  endtask

  task automatic test_reset_midflight();
    for (int k = 0; k < 3; k++) begin
      req = 1'b1; mwe = 1'b0; maddr = 16'(10 + k);
      tick();
    end
    req = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < N; i++) begin
      total++;
      if ({o_mv[i], o_rd[i], o_wr[i], o_err[i], o_md[i]} !== '0) begin
        bad++; $display("FAIL mid_rst dut%0d vld=%b rd=%0d wr=%0d err=%b data=%h want all 0",
                        i, o_mv[i], o_rd[i], o_wr[i], o_err[i], o_md[i]);
      end
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      total++;
      if (o_mv !== '0) begin bad++; $display("FAIL ghost_rsp cyc%0d got=%b want=0", k, o_mv); end
    end
    for (int i = 0; i < N; i++) got[i].delete();
    mem_op(1'b0, 16'd10, 32'h0);
    for (int i = 0; i < N; i++) if (o_mv[i]) got[i].push_back(o_md[i]);
    repeat (9) begin
      tick();
      for (int i = 0; i < N; i++) if (o_mv[i]) got[i].push_back(o_md[i]);
    end
    for (int i = 0; i < N; i++) begin
      total++;
      if (got[i].size() != 1 || got[i][0] !== mdl[10] || o_rd[i] !== 32'd1) begin
        bad++; $display("FAIL post_rst dut%0d got n=%0d data=%h rd=%0d want 1/%h/1", i, got[i].size(),
                        got[i].size() > 0 ? got[i][0] : 32'hx, o_rd[i], mdl[10]);
      end
    end
  endtask

  task automatic test_latency_sweep();
    int vc [N];
    for (int i = 0; i < N; i++) vc[i] = 0;
    for (int k = 0; k < 28; k++) begin
      req = (k < 16) && (k % 2 == 0); mwe = 1'b0; maddr = 16'($urandom_range(0, 63));
      tick();
      for (int i = 0; i < N; i++) begin
        vc[i] += int'(o_mv[i]);
        total++;
        if ({o_mv[i], o_md[i]} !== {e_mv[i], e_md[i]}) begin
          bad++; $display("FAIL sweep dut%0d cyc%0d got %b/%h want %b/%h", i, k, o_mv[i], o_md[i], e_mv[i], e_md[i]);
        end
      end
    end
    req = 1'b0;
    for (int i = 0; i < N; i++) begin
      total++;
      if (vc[i] != 8) begin bad++; $display("FAIL sweep_count dut%0d got=%0d want=8", i, vc[i]); end
    end
  endtask

  task automatic test_random();
    logic gnt_exp;
    for (int k = 0; k < 400; k++) begin
      req   = 1'($urandom_range(0, 1));
      mwe   = ($urandom_range(0, 3) == 0);
      maddr = ($urandom_range(0, 15) == 0) ? 16'(16'h0400 + $urandom_range(0, 63)) : 16'($urandom_range(0, 63));
      mwd   = $urandom;
      if (!hreq && $urandom_range(0, 2) == 0) begin
        hreq = 1'b1; hwe = ($urandom_range(0, 2) == 0);
        haddr = 16'($urandom_range(0, 70)); hwd = $urandom;
      end
      gnt_exp = hreq & ~req;
      #1;
      total++;
      if (o_gnt !== {N{gnt_exp}}) begin bad++; $display("FAIL rnd_gnt cyc%0d got=%b want=%b", k, o_gnt, gnt_exp); end
      tick();
      if (gnt_exp) hreq = 1'b0;
      for (int i = 0; i < N; i++) begin
        total++;
        if ({o_mv[i], o_md[i], o_hv[i], o_hd[i], o_rd[i], o_wr[i], o_err[i]} !==
            {e_mv[i], e_md[i], e_hv[i], e_hd[i], e_rd, e_wr, e_err}) begin
          bad++;
          $display("FAIL rnd dut%0d cyc%0d got m=%b/%h h=%b/%h cnt=%0d/%0d err=%b want m=%b/%h h=%b/%h cnt=%0d/%0d err=%b",
                   i, k, o_mv[i], o_md[i], o_hv[i], o_hd[i], o_rd[i], o_wr[i], o_err[i],
                   e_mv[i], e_md[i], e_hv[i], e_hd[i], e_rd, e_wr, e_err);
        end
      end
    end
    req = 1'b0; hreq = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_preload();
    test_host_then_read();
    test_raw();
    test_arbitration();
    test_out_of_range();
    test_reset_midflight();
    test_latency_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder (memory side) for the single-request-per-cycle memory interface driven by the memory-to-memory compute engines, e.g. the matrix multiplier.
- Holds a synchronous word array, answers reads in order after a fixed latency and commits writes immediately.
- Provides a secondary host port so a bench or host can preload operands and read back results.
- Tracks read/write statistics and flags out-of-range accesses.

Parameters:
- MEM_AW, 16: initiator/host address width.
- MEM_DW, 32: data word width.
- DEPTH_AW, 10: array holds 2**DEPTH_AW words at addresses 0..2**DEPTH_AW-1.
- RD_LAT, 2: read latency in cycles; legal range 1..8.
- CNT_W, 32: width of the statistics counters.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- mem_req, in, 1: initiator request valid; each cycle it is high is one transaction.
- mem_write, in, 1: 1 = write, 0 = read; qualified by mem_req.
- mem_addr, in, MEM_AW: initiator word address.
- mem_wdata, in, MEM_DW: initiator write data.
- mem_rdata_vld, out, 1: initiator read data valid, one-cycle pulse per read.
- mem_rdata, out, MEM_DW: initiator read data.
- host_req, in, 1: host request; held until granted.
- host_we, in, 1: host write enable.
- host_addr, in, MEM_AW: host word address.
- host_wdata, in, MEM_DW: host write data.
- host_gnt, out, 1: combinational; host_req & ~mem_req.
- host_rdata_vld, out, 1: host read data valid pulse.
- host_rdata, out, MEM_DW: host read data.
- rd_cnt, out, CNT_W: initiator reads accepted.
- wr_cnt, out, CNT_W: initiator writes accepted.
- addr_err, out, 1: sticky out-of-range flag.

Behaviour:
- No backpressure toward the initiator. Every cycle with mem_req=1 is accepted at the rising edge that ends that cycle.
- Arbitration: the initiator always wins. The host is served only in cycles where mem_req=0 and host_req=1. A host transaction is accepted on the edge where host_gnt=1, and the host must hold its request until then.
- Write: the array location is updated at the accepting edge. A read of the same address accepted in the next cycle returns the new data (read-after-write, no bypass needed). Writes produce no response.
- Read latency:
  - A read accepted at the end of cycle N drives its data valid during cycle N+RD_LAT (RD_LAT=1 means the next cycle).
  - Responses come back strictly in order, up to RD_LAT reads in flight, at full throughput of one read per cycle.
  - Implementation: RD_LAT-deep shift pipeline of {valid, source-tag, data}. The tag selects mem_rdata_vld or host_rdata_vld.
  - Array read happens at the accepting edge; the remaining stages are registers.
- mem_rdata and host_rdata hold their last delivered value when their valid is low. Each valid is high exactly one cycle per read.
- Address range: an address is in range iff bits [MEM_AW-1:DEPTH_AW] are all zero (always true when DEPTH_AW >= MEM_AW). For an out-of-range access, on either port:
  - A write is dropped.
  - A read still returns a response, with data 0, at the normal latency.
  - addr_err sets and stays set until rst.
- Counters: rd_cnt and wr_cnt increment on each accepted initiator read or write and wrap modulo 2**CNT_W. Out-of-range accesses count. Host accesses do not count.
- Reset (asynchronous, any time, including mid-burst):
  - mem_rdata_vld, host_rdata_vld, mem_rdata, host_rdata, rd_cnt, wr_cnt and addr_err all go to 0.
  - All in-flight pipeline entries are discarded; no response is produced for reads accepted before rst.
  - Array contents are not reset and are preserved across rst.
- An X on mem_req or host_req while rst=0 is a protocol violation. The bench asserts against it; the RTL does not need to handle it.
- Simultaneous mem_req=1 and host_req=1: the initiator is served, host_gnt=0, and the host stalls. The host can starve indefinitely under continuous mem_req; this is accepted.

Test Plan:
- Host preload then initiator read: host writes 0x11 to addr 5 and 0x22 to addr 6; initiator reads 5 and 6 in back-to-back cycles N, N+1 with RD_LAT=2. Required: mem_rdata_vld high in cycles N+2 and N+3 with data 0x11 then 0x22; rd_cnt=2.
- Read-after-write: initiator writes 0xDEADBEEF to addr 3 in cycle N and reads addr 3 in N+1. Required: the response in N+1+RD_LAT is 0xDEADBEEF; wr_cnt=1.
- Arbitration: host_req held high while mem_req is high for cycles N..N+3. Required: host_gnt=0 for N..N+3 and 1 in N+4; the host read response is tagged to host_rdata_vld only, never to mem_rdata_vld.
- Out-of-range with DEPTH_AW=10: initiator writes 0x55 to addr 0x0400, then reads addr 0x0400 and addr 0x0000. Required: addr 0x0000 is unchanged, the 0x0400 read returns 0, addr_err=1 and stays 1.
- Reset mid-flight with RD_LAT=4: three reads are accepted, then rst pulses before the first response. Required: no mem_rdata_vld pulse after rst, counters are 0, and a later read returns the pre-reset array contents.
- Latency sweep over RD_LAT=1,3,8 with a matmul-style pattern (read every other cycle, 8 reads). Required: every response arrives exactly RD_LAT cycles after acceptance, in order, with no dropped or duplicated valids.
